// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter
// Round-robin arbiter that shares one ethernet_tx frame transmitter between two
// frame sources. It grants one requester at a time, forwards that requester's
// payload dibits with one cycle of latency, and latches its destination MAC and
// ethertype. Short payloads are zero-padded to the Ethernet minimum. After the
// transmitter finishes, an inter-frame gap is enforced before the next grant.
//
// Ports:
//   clk           system clock (50 MHz RMII domain)
//   rst_n         asynchronous active-low reset
//   req[1:0]      per-requester frame request (level, held until grant seen)
//   gnt[1:0]      one-hot grant, high only while waiting for / streaming payload
//   src_axiid     payload dibits: [1:0] requester 0, [3:2] requester 1
//   src_axiiv     per-requester payload valid
//   src_dest_mac  destination MACs: [47:0] requester 0, [95:48] requester 1
//   src_etype     ethertypes: [15:0] requester 0, [31:16] requester 1
//   tx_busy       transmitter busy (ethernet_tx axiov)
//   tx_axiid      payload dibit to the transmitter (registered)
//   tx_axiiv      payload valid to the transmitter (registered)
//   tx_dest_mac   latched destination MAC of the current frame
//   tx_etype      latched ethertype of the current frame
//   idle          high while the arbiter is waiting for a request
module eth_tx_arbiter #(
  parameter int MIN_DIBITS = 184,
  parameter int IFG_CYCLES = 48,
  parameter int TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  input  logic [3:0]  src_axiid,
  input  logic [1:0]  src_axiiv,
  input  logic [95:0] src_dest_mac,
  input  logic [31:0] src_etype,
  input  logic        tx_busy,
  output logic [1:0]  tx_axiid,
  output logic        tx_axiiv,
  output logic [47:0] tx_dest_mac,
  output logic [15:0] tx_etype,
  output logic        idle
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_STREAM  = 3'd2;
  localparam logic [2:0] S_PAD     = 3'd3;
  localparam logic [2:0] S_WAIT_TX = 3'd4;
  localparam logic [2:0] S_GAP     = 3'd5;

  localparam logic [15:0] MIN_LEN  = 16'(MIN_DIBITS);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        last_q, last_d;
  logic        win_q, win_d;
  logic [1:0]  axiid_q, axiid_d;
  logic        axiiv_q, axiiv_d;
  logic [47:0] mac_q, mac_d;
  logic [15:0] etype_q, etype_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] timer_q, timer_d;
  logic        busy_seen_q, busy_seen_d;

  logic        win_valid;
  logic [1:0]  win_dibit;
  logic [15:0] cnt_inc;
  logic        pick;

  // Only the granted requester's stream is looked at; the other side is ignored.
  assign win_valid = src_axiiv[win_q];
  assign win_dibit = win_q ? src_axiid[3:2] : src_axiid[1:0];
  // Dibit counter saturates rather than wrapping on very long payloads.
  assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  // On contention the requester that did not win last time is chosen.
  assign pick      = (req == 2'b11) ? ~last_q : req[1];

  // Next-state logic for the frame sequencing FSM and its datapath.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    win_d       = win_q;
    axiid_d     = 2'b00;
    axiiv_d     = 1'b0;
    mac_d       = mac_q;
    etype_d     = etype_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    busy_seen_d = busy_seen_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          win_d   = pick;
          last_d  = pick;
          gnt_d   = pick ? 2'b10 : 2'b01;
          mac_d   = pick ? src_dest_mac[95:48] : src_dest_mac[47:0];
          etype_d = pick ? src_etype[31:16] : src_etype[15:0];
          timer_d = 16'd0;
          cnt_d   = 16'd0;
          state_d = S_START;
        end
      end
      S_START: begin
        // The first valid dibit is forwarded right away so latency stays one cycle.
        if (win_valid) begin
          axiid_d = win_dibit;
          axiiv_d = 1'b1;
          cnt_d   = 16'd1;
          state_d = S_STREAM;
        end else if (timer_q == TO_LAST) begin
          gnt_d   = 2'b00;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      S_STREAM: begin
        if (win_valid) begin
          axiid_d = win_dibit;
          axiiv_d = 1'b1;
          cnt_d   = cnt_inc;
        end else begin
          gnt_d       = 2'b00;
          timer_d     = 16'd0;
          busy_seen_d = 1'b0;
          if (cnt_q >= MIN_LEN) begin
            state_d = S_WAIT_TX;
          end else begin
            // First pad dibit issued here so tx_axiiv has no bubble.
            axiiv_d = 1'b1;
            cnt_d   = cnt_inc;
            state_d = S_PAD;
          end
        end
      end
      S_PAD: begin
        if (cnt_q < MIN_LEN) begin
          axiiv_d = 1'b1;
          cnt_d   = cnt_inc;
        end else begin
          timer_d     = 16'd0;
          busy_seen_d = 1'b0;
          state_d     = S_WAIT_TX;
        end
      end
      S_WAIT_TX: begin
        // Look for a busy high-then-low; give up if busy never rises.
        if (tx_busy) begin
          busy_seen_d = 1'b1;
        end
        if (busy_seen_q && !tx_busy) begin
          timer_d = 16'd0;
          state_d = S_GAP;
        end else if (!busy_seen_q && !tx_busy && timer_q == TO_LAST) begin
          timer_d = 16'd0;
          state_d = S_GAP;
        end else if (!busy_seen_q) begin
          timer_d = timer_q + 16'd1;
        end
      end
      S_GAP: begin
        if (timer_q == IFG_LAST) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  // State registers; last-grant resets to 1 so requester 0 wins first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gnt_q       <= 2'b00;
      last_q      <= 1'b1;
      win_q       <= 1'b0;
      axiid_q     <= 2'b00;
      axiiv_q     <= 1'b0;
      mac_q       <= 48'd0;
      etype_q     <= 16'd0;
      cnt_q       <= 16'd0;
      timer_q     <= 16'd0;
      busy_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      win_q       <= win_d;
      axiid_q     <= axiid_d;
      axiiv_q     <= axiiv_d;
      mac_q       <= mac_d;
      etype_q     <= etype_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      busy_seen_q <= busy_seen_d;
    end
  end

  assign gnt         = gnt_q;
  assign tx_axiid    = axiid_q;
  assign tx_axiiv    = axiiv_q;
  assign tx_dest_mac = mac_q;
  assign tx_etype    = etype_q;
  assign idle        = (state_q == S_IDLE);

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter
// Self-checking bench for eth_tx_arbiter. Payload dibits (and pad zeros) are
// pushed to a scoreboard queue as they are driven and popped when the arbiter
// presents them on tx_axiiv/tx_axiid. A small transmitter model drives tx_busy.
module tb_eth_tx_arbiter;

  localparam int MIN_DIBITS = 184;
  localparam int IFG_CYCLES = 48;
  localparam int TIMEOUT    = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic [3:0]  src_axiid;
  logic [1:0]  src_axiiv;
  logic [95:0] src_dest_mac;
  logic [31:0] src_etype;
  logic        tx_busy = 1'b0;
  logic [1:0]  tx_axiid;
  logic        tx_axiiv;
  logic [47:0] tx_dest_mac;
  logic [15:0] tx_etype;
  logic        idle;

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;
  int expLen = -1;
  int runLen = 0;
  int firstTxCycle = -1;
  int srcStartCycle = 0;
  int busyTail = 0;
  int busyFallCycle = 0;
  logic [2:0] sbQ[$];
  logic [2:0] monExp;

  eth_tx_arbiter #(
    .MIN_DIBITS(MIN_DIBITS),
    .IFG_CYCLES(IFG_CYCLES),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .gnt(gnt),
    .src_axiid(src_axiid),
    .src_axiiv(src_axiiv),
    .src_dest_mac(src_dest_mac),
    .src_etype(src_etype),
    .tx_busy(tx_busy),
    .tx_axiid(tx_axiid),
    .tx_axiiv(tx_axiiv),
    .tx_dest_mac(tx_dest_mac),
    .tx_etype(tx_etype),
    .idle(idle)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Transmitter model: busy while payload flows, plus a short trailer (FCS).
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy  = 1'b0;
      busyTail = 0;
    end else if (tx_axiiv) begin
      tx_busy  = 1'b1;
      busyTail = 8;
    end else if (busyTail > 1) begin
      busyTail--;
    end else if (tx_busy) begin
      tx_busy       = 1'b0;
      busyTail      = 0;
      busyFallCycle = cycleCount;
    end
  end

  // Output monitor: pops the scoreboard on every valid dibit, checks frame length.
  always @(negedge clk) begin
    if (tx_axiiv) begin
      if (runLen == 0) firstTxCycle = cycleCount;
      runLen++;
      if (sbQ.size() > 0) monExp = sbQ.pop_front();
      else monExp = 3'b100;
      checkOutput("txData", {1'b0, tx_axiid}, monExp);
    end else if (runLen > 0) begin
      if (expLen >= 0) checkOutput("frameLen", runLen, expLen);
      runLen = 0;
    end
  end

  // Wait for any grant and check which requester won and how quickly.
  task automatic waitGnt(input logic [1:0] want, input string tag);
    int waited = 0;
    while (gnt == 2'b00 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    checkOutput(tag, gnt, want);
    checkOutput({tag, "Lat"}, waited, 1);
  endtask

  // Stream n dibits from requester r and push the expected output (with pads).
  task automatic applyStimulus(input int r, input int n, input int pattern, input int changeAt);
    logic [1:0] d;
    expLen = (n < MIN_DIBITS) ? MIN_DIBITS : n;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      case (pattern)
        0:       d = 2'(i % 4);
        1:       d = 2'b11;
        default: d = 2'($urandom_range(0, 3));
      endcase
      if (i == 0) srcStartCycle = cycleCount;
      if (i == changeAt) begin
        src_dest_mac = ~src_dest_mac;
        src_etype    = ~src_etype;
      end
      src_axiid[2*r +: 2] = d;
      src_axiiv[r]        = 1'b1;
      sbQ.push_back({1'b0, d});
    end
    @(negedge clk);
    src_axiiv[r] = 1'b0;
    src_axiid    = 4'd0;
    for (int i = n; i < MIN_DIBITS; i++) sbQ.push_back(3'b000);
  endtask

  // Wait for the gap to finish; optionally check the latched header holds.
  task automatic waitIdle(input logic holdChk, input logic [47:0] mac, input logic [15:0] et);
    int waited = 0;
    while (!idle && waited < 3000) begin
      if (holdChk) begin
        checkOutput("macHold", tx_dest_mac, mac);
        checkOutput("etypeHold", tx_etype, et);
      end
      @(negedge clk);
      waited++;
    end
    checkOutput("idleReached", idle, 1'b1);
    checkOutput("gapLen", cycleCount - busyFallCycle - 1, IFG_CYCLES);
    checkOutput("sbDrained", sbQ.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycleCount);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [47:0] expMac;
    logic [15:0] expEt;
    int hi;

    rst_n        = 1'b0;
    req          = 2'b00;
    src_axiid    = 4'd0;
    src_axiiv    = 2'b00;
    src_dest_mac = {48'h0011_2233_4455, 48'hFEDC_BA98_7654};
    src_etype    = {16'h88B5, 16'h6789};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset values
    checkOutput("rstGnt", gnt, 2'b00);
    checkOutput("rstAxiiv", tx_axiiv, 1'b0);
    checkOutput("rstAxiid", tx_axiid, 2'b00);
    checkOutput("rstMac", tx_dest_mac, 48'd0);
    checkOutput("rstEtype", tx_etype, 16'd0);
    checkOutput("rstIdle", idle, 1'b1);

    // Both requesting from reset: requester 0 first; header latched and held
    req = 2'b11;
    waitGnt(2'b01, "firstGnt");
    req[0] = 1'b0;
    checkOutput("macLatch", tx_dest_mac, 48'hFEDC_BA98_7654);
    checkOutput("etypeLatch", tx_etype, 16'h6789);
    applyStimulus(0, 40, 2, 20);
    waitIdle(1'b1, 48'hFEDC_BA98_7654, 16'h6789);

    // Pending requester 1 wins next; short frame gets padded
    expMac = src_dest_mac[95:48];
    expEt  = src_etype[31:16];
    waitGnt(2'b10, "altGnt");
    req[1] = 1'b0;
    checkOutput("mac1Latch", tx_dest_mac, expMac);
    checkOutput("etype1Latch", tx_etype, expEt);
    applyStimulus(1, 10, 1, -1);
    waitIdle(1'b1, expMac, expEt);

    // Both again: alternation returns to requester 0; 200-dibit unpadded frame
    req = 2'b11;
    waitGnt(2'b01, "reAltGnt");
    req[0] = 1'b0;
    applyStimulus(0, 200, 0, -1);
    checkOutput("txLatency", firstTxCycle - srcStartCycle, 1);
    waitIdle(1'b0, 48'd0, 16'd0);
    waitGnt(2'b10, "pendGnt");
    req[1] = 1'b0;
    applyStimulus(1, 3, 2, -1);
    waitIdle(1'b0, 48'd0, 16'd0);

    // Grant with no payload is released after the start timeout
    req = 2'b01;
    waitGnt(2'b01, "toGnt");
    req = 2'b00;
    hi = 1;
    while (gnt != 2'b00 && hi < TIMEOUT + 100) begin
      @(negedge clk);
      if (gnt != 2'b00) hi++;
    end
    checkOutput("startTimeout", hi, TIMEOUT);
    checkOutput("idleAfterTo", idle, 1'b1);
    req = 2'b10;
    waitGnt(2'b10, "gntAfterTo");
    req = 2'b00;
    applyStimulus(1, 5, 2, -1);
    waitIdle(1'b0, 48'd0, 16'd0);

    // Reset in the middle of a stream
    expLen = -1;
    req = 2'b01;
    waitGnt(2'b01, "preRstGnt");
    req = 2'b00;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      src_axiid[1:0] = 2'($urandom_range(0, 3));
      src_axiiv[0]   = 1'b1;
      sbQ.push_back({1'b0, src_axiid[1:0]});
    end
    @(negedge clk);
    #3 rst_n = 1'b0;
    src_axiiv = 2'b00;
    #1;
    checkOutput("midRstGnt", gnt, 2'b00);
    checkOutput("midRstAxiiv", tx_axiiv, 1'b0);
    checkOutput("midRstAxiid", tx_axiid, 2'b00);
    checkOutput("midRstMac", tx_dest_mac, 48'd0);
    checkOutput("midRstEtype", tx_etype, 16'd0);
    checkOutput("midRstIdle", idle, 1'b1);
    sbQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    req = 2'b11;
    waitGnt(2'b01, "postRstGnt");
    req = 2'b00;
    applyStimulus(0, 190, 2, -1);
    waitIdle(1'b0, 48'd0, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
- Shares the single ethernet_tx frame transmitter (2-bit dibit payload stream) between two frame sources, e.g. controller-state reports and debug/video packets.
- Grants one requester at a time, round-robin, and muxes that requester's payload dibits, dest MAC and ethertype into ethernet_tx.
- Zero-pads short payloads to the Ethernet minimum, waits for the transmitter to finish, then enforces the inter-frame gap before the next grant.

Parameters:
- MIN_DIBITS, 184, minimum payload length in dibits (46 bytes); shorter payloads are zero-padded.
- IFG_CYCLES, 48, idle cycles after transmitter completion (96 bit-times at 2 bits/cycle).
- TIMEOUT, 1024, cycle limit for start-of-payload wait and for the transmitter busy-rise wait.

Ports:
- clk  in  1  system clock (50 MHz RMII domain)
- rst_n  in  1  asynchronous active-low reset
- req  in  2  per-requester frame request, level; held until grant is seen
- gnt  out  2  one-hot grant; at most one bit set
- src_axiid  in  4  dibits: [1:0] requester 0, [3:2] requester 1
- src_axiiv  in  2  per-requester payload valid
- src_dest_mac  in  96  [47:0] req 0, [95:48] req 1
- src_etype  in  32  [15:0] req 0, [31:16] req 1
- tx_busy  in  1  ethernet_tx axiov (high while frame on wire)
- tx_axiid  out  2  payload dibit to ethernet_tx
- tx_axiiv  out  1  payload valid to ethernet_tx
- tx_dest_mac  out  48  latched destination MAC
- tx_etype  out  16  latched ethertype
- idle  out  1  high in IDLE state

Behaviour:
- Reset (async, rst_n low): state IDLE; gnt=0; tx_axiid=0; tx_axiiv=0; tx_dest_mac=0; tx_etype=0; idle=1; last-grant pointer=1, so requester 0 wins the first contention.
- IDLE: if any req bit is set, pick a winner.
  - Both requesting: grant the index not equal to last-grant.
  - Otherwise grant the sole requester.
  - Latch the winner's dest_mac/etype into tx_dest_mac/tx_etype.
  - Set gnt one-hot, update last-grant, go to START. Grant takes one cycle from req.
- START: wait for the winner's src_axiiv.
  - No valid within TIMEOUT cycles: drop gnt and go to IDLE (abandoned; last-grant still updated).
  - Loser's valid and req are ignored in every state.
- STREAM: entered on the first winner valid.
  - Each valid cycle: tx_axiid<=winner dibit, tx_axiiv<=1, dibit counter++. Registered output, 1-cycle latency.
  - Payload must be contiguous. The first cycle with winner valid low ends the payload; gnt drops that same cycle.
  - count>=MIN_DIBITS: go to WAIT_TX.
  - count<MIN_DIBITS: go to PAD.
  - Counter is 16 bits and saturates at 65535; it does not wrap.
- PAD: drive tx_axiiv=1, tx_axiid=0 until total dibits = MIN_DIBITS. tx_axiiv stays continuous across the STREAM->PAD boundary with no bubble. Then go to WAIT_TX.
- WAIT_TX: tx_axiiv=0.
  - Wait for tx_busy to be seen high, then low; falling edge -> GAP.
  - tx_busy never rises within TIMEOUT cycles: go to GAP anyway.
- GAP: count IFG_CYCLES cycles, then go to IDLE. tx_dest_mac/tx_etype hold until GAP exits. req is ignored during GAP.
- gnt is high only in START and STREAM.
- idle=1 only in IDLE.
- Simultaneous events:
  - req changing during a frame has no effect.
  - A requester dropping req during START does not cancel the grant; only the timeout releases it.
- Reset mid-frame: all outputs return to reset values immediately; ethernet_tx sees tx_axiiv fall and terminates its frame itself.

Test Plan:
- Req0 only, 200 valid dibits of pattern i%4 -> gnt=01 one cycle after req; tx_axiiv high 200 cycles, one cycle delayed from src_axiiv[0], dibits match; no pad; WAIT_TX until tx_busy falls; then 48 GAP cycles with idle=0, then idle=1.
- Req1 only, 10 dibits of 2'b11 -> 10 dibits of 11, then 174 dibits of 00; tx_axiiv high exactly 184 contiguous cycles.
- Both req asserted from reset -> requester 0 granted first, requester 1 granted after req0 frame and gap. Then both re-asserted -> requester 0 granted again (alternation).
- Latch check: dest_mac 48'hFE_DC_BA_98_76_54, etype 16'h6789 on req0; change src inputs mid-frame -> tx_dest_mac/tx_etype stay constant through GAP.
- Req0 granted, never asserts valid -> gnt drops after 1024 cycles, idle=1; a subsequent req1 is granted next.
- Assert rst_n low for 1 cycle mid-STREAM -> gnt=0, tx_axiiv=0, outputs zeroed immediately; the next request after reset is granted to requester 0.
